// File: rtl/turf_udp_fragmenter.sv
// turf_udp_fragmenter
// Splits one event (announced by a tag+length control word) into UDP-sized
// fragments: a registered header beat followed by up to FRAG_BEATS payload
// beats passed straight through from the 64-bit payload stream.
`timescale 1ns/1ps

module turf_udp_fragmenter #(
  parameter int unsigned FRAG_BEATS = 128,
  parameter logic [15:0] MAGIC      = 16'h5446
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_ctrl_tdata,
  input  logic        s_ctrl_tvalid,
  output logic        s_ctrl_tready,
  input  logic [63:0] s_data_tdata,
  input  logic        s_data_tvalid,
  input  logic        s_data_tlast,
  output logic        s_data_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [31:0] event_count,
  output logic        err_tlast
);

  localparam logic [19:0] FRAG_BYTES   = 20'(8 * FRAG_BEATS);
  localparam logic [17:0] FRAG_BEATS_W = 18'(FRAG_BEATS);
  localparam logic [8:0]  FRAG_LAST    = 9'(FRAG_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t      state;
  logic [11:0] tag_r;
  logic [11:0] nfrag_r;
  logic [11:0] frag_idx;
  logic [19:0] bytes_left;   // event bytes from the start of the current fragment
  logic [17:0] beats_left;   // event payload beats not yet transferred
  logic [8:0]  frag_cnt;     // payload beats transferred in the current fragment
  logic [2:0]  rem_r;
  logic        len_zero;
  logic [63:0] hdr_r;

  logic [19:0] ctrl_len;
  logic [11:0] ctrl_tag;
  logic [17:0] ctrl_beats;
  logic [11:0] ctrl_nfrag;

  logic [11:0] hdr_tag;
  logic [11:0] hdr_idx;
  logic [11:0] hdr_nfrag;
  logic [19:0] hdr_left;
  logic [11:0] hdr_fbytes;
  logic [63:0] hdr_next;

  logic        xfer;
  logic        last_evt;
  logic        last_frag;
  logic [7:0]  keep_rem;

  // Decode the incoming control word into the per-event derived values
  always_comb begin
    ctrl_len   = s_ctrl_tdata[19:0];
    ctrl_tag   = s_ctrl_tdata[31:20];
    ctrl_beats = 18'((21'(ctrl_len) + 21'd7) >> 3);
    if (ctrl_beats == 18'd0)
      ctrl_nfrag = 12'd1;
    else
      ctrl_nfrag = 12'((ctrl_beats + (FRAG_BEATS_W - 18'd1)) / FRAG_BEATS_W);
  end

  // Header contents for the next HEADER entry: either the first fragment of a
  // new event (from the control word) or the following fragment of this one
  always_comb begin
    hdr_tag   = tag_r;
    hdr_idx   = frag_idx + 12'd1;
    hdr_nfrag = nfrag_r;
    hdr_left  = bytes_left - FRAG_BYTES;
    if (state == IDLE) begin
      hdr_tag   = ctrl_tag;
      hdr_idx   = 12'd0;
      hdr_nfrag = ctrl_nfrag;
      hdr_left  = ctrl_len;
    end
    hdr_fbytes = (hdr_left >= FRAG_BYTES) ? 12'(FRAG_BYTES) : hdr_left[11:0];
    hdr_next   = {MAGIC, hdr_tag, hdr_idx, hdr_nfrag, hdr_fbytes};
  end

  // Beat-level framing flags for the pass-through phase
  always_comb begin
    xfer      = (state == STREAM) && s_data_tvalid && m_axis_tready;
    last_evt  = (beats_left == 18'd1);
    last_frag = last_evt || (frag_cnt == FRAG_LAST);
    keep_rem  = (rem_r == 3'd0) ? 8'hFF : ~(8'hFF << rem_r);
  end

  // Output muxing per state; STREAM is a combinational pass-through
  always_comb begin
    s_ctrl_tready = 1'b0;
    s_data_tready = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state)
      IDLE: begin
        s_ctrl_tready = 1'b1;
      end
      HEADER: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_r;
        m_axis_tkeep  = '1;
        m_axis_tlast  = len_zero;
      end
      STREAM: begin
        m_axis_tvalid = s_data_tvalid;
        s_data_tready = m_axis_tready;
        m_axis_tdata  = s_data_tdata;
        m_axis_tkeep  = last_evt ? keep_rem : 8'hFF;
        m_axis_tlast  = last_frag;
      end
      default: begin
        s_ctrl_tready = 1'b0;
      end
    endcase
  end

  // Event/fragment sequencing, counters and sticky tlast error
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      tag_r       <= '0;
      nfrag_r     <= '0;
      frag_idx    <= '0;
      bytes_left  <= '0;
      beats_left  <= '0;
      frag_cnt    <= '0;
      rem_r       <= '0;
      len_zero    <= 1'b0;
      hdr_r       <= '0;
      event_count <= '0;
      err_tlast   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_ctrl_tvalid) begin
            tag_r      <= ctrl_tag;
            nfrag_r    <= ctrl_nfrag;
            frag_idx   <= '0;
            bytes_left <= ctrl_len;
            beats_left <= ctrl_beats;
            frag_cnt   <= '0;
            rem_r      <= ctrl_len[2:0];
            len_zero   <= (ctrl_len == 20'd0);
            hdr_r      <= hdr_next;
            state      <= HEADER;
          end
        end
        HEADER: begin
          if (m_axis_tready) begin
            if (len_zero) begin
              event_count <= event_count + 32'd1;
              state       <= IDLE;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (xfer) begin
            if (s_data_tlast != last_evt)
              err_tlast <= 1'b1;
            beats_left <= beats_left - 18'd1;
            frag_cnt   <= frag_cnt + 9'd1;
            if (last_frag) begin
              if (last_evt) begin
                event_count <= event_count + 32'd1;
                state       <= IDLE;
              end else begin
                frag_idx   <= frag_idx + 12'd1;
                bytes_left <= bytes_left - FRAG_BYTES;
                frag_cnt   <= '0;
                hdr_r      <= hdr_next;
                state      <= HEADER;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turf_udp_fragmenter.sv
// Testbench for turf_udp_fragmenter: directed and randomized events checked
// against a byte-count based fragment model.
`timescale 1ns/1ps

module tb_turf_udp_fragmenter;

  localparam int unsigned FB    = 128;
  localparam logic [15:0] MAGIC = 16'h5446;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_ctrl_tdata = '0;
  logic        s_ctrl_tvalid = 1'b0;
  logic        s_ctrl_tready;
  logic [63:0] s_data_tdata = '0;
  logic        s_data_tvalid = 1'b0;
  logic        s_data_tlast = 1'b0;
  logic        s_data_tready;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic [31:0] event_count;
  logic        err_tlast;

  turf_udp_fragmenter #(.FRAG_BEATS(FB), .MAGIC(MAGIC)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_ctrl_tdata(s_ctrl_tdata), .s_ctrl_tvalid(s_ctrl_tvalid), .s_ctrl_tready(s_ctrl_tready),
    .s_data_tdata(s_data_tdata), .s_data_tvalid(s_data_tvalid), .s_data_tlast(s_data_tlast),
    .s_data_tready(s_data_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .event_count(event_count), .err_tlast(err_tlast)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       got_q[$];
  logic [63:0] pay_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          timeouts = 0;
  int          stall_viol = 0;
  int          sdata_xfers = 0;
  bit          rand_ready = 1'b0;
  bit          rand_valid = 1'b0;
  bit          ready_level = 1'b1;
  logic [31:0] ev_exp = '0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  // Output collector and stall-stability watcher, sampled mid-cycle
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data)) stall_viol++;
      if (m_axis_tvalid && m_axis_tready)
        got_q.push_back(beat_t'{m_axis_tdata, m_axis_tkeep, m_axis_tlast});
      if (s_data_tvalid && s_data_tready) sdata_xfers++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
    end
  end

  // Downstream ready generator
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got %0d expected finish", $time);
    $fatal(1);
  end

  // Expected output of one event, derived from byte counts alone
  function automatic void model_event(input logic [11:0] tag, input int unsigned len);
    int unsigned fbb = 8 * FB;
    int unsigned nfrag = (len == 0) ? 1 : (len + fbb - 1) / fbb;
    int unsigned p = 0;
    for (int unsigned f = 0; f < nfrag; f++) begin
      int unsigned fbytes = (len - f * fbb < fbb) ? len - f * fbb : fbb;
      exp_q.push_back(beat_t'{{MAGIC, tag, 12'(f), 12'(nfrag), 12'(fbytes)}, 8'hFF, (len == 0)});
      for (int unsigned b = 0; b * 8 < fbytes; b++) begin
        int unsigned nb = fbytes - b * 8;
        logic [7:0] k;
        if (nb > 8) nb = 8;
        k = (nb == 8) ? 8'hFF : 8'((32'd1 << nb) - 32'd1);
        exp_q.push_back(beat_t'{pay_q[p], k, ((b + 1) * 8 >= fbytes)});
        p++;
      end
    end
  endfunction

  task automatic send_ctrl(input logic [11:0] tag, input int unsigned len);
    bit acc;
    s_ctrl_tdata  = {tag, 20'(len)};
    s_ctrl_tvalid = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge aclk);
      acc = s_ctrl_tready;
      @(posedge aclk);
      #1;
      if (acc) break;
      if (c == 3999) timeouts++;
    end
    s_ctrl_tvalid = 1'b0;
  endtask

  task automatic send_data(input int n, input int early);
    bit acc;
    for (int i = 0; i < n; i++) begin
      while (rand_valid && ($urandom_range(0, 1) == 0)) begin
        s_data_tvalid = 1'b0;
        @(posedge aclk);
        #1;
      end
      s_data_tdata  = pay_q[i];
      s_data_tlast  = (i == n - 1) || (i == early);
      s_data_tvalid = 1'b1;
      for (int c = 0; c < 2000; c++) begin
        @(negedge aclk);
        acc = s_data_tvalid && s_data_tready;
        @(posedge aclk);
        #1;
        if (acc) break;
        if (c == 1999) timeouts++;
      end
    end
    s_data_tvalid = 1'b0;
    s_data_tlast  = 1'b0;
  endtask

  task automatic run_event(input logic [11:0] tag, input int unsigned len, input int early);
    int nb = int'((len + 7) / 8);
    int target;
    pay_q.delete();
    for (int i = 0; i < nb; i++) pay_q.push_back({$urandom, $urandom});
    model_event(tag, len);
    target = exp_q.size();
    fork
      send_ctrl(tag, len);
      send_data(nb, early);
    join
    for (int c = 0; c < 4000 && got_q.size() < target; c++) @(posedge aclk);
    if (got_q.size() < target) timeouts++;
    @(posedge aclk);
    #1;
    ev_exp++;
  endtask

  task automatic test_reset();
    ready_level = 1'b1;
    aresetn = 1'b0;
    #23;
    n_checks++; if (s_ctrl_tready !== 1'b1) $display("FAIL reset_ctrl_tready: got %b expected 1", s_ctrl_tready); else n_pass++;
    n_checks++; if (s_data_tready !== 1'b0) $display("FAIL reset_data_tready: got %b expected 0", s_data_tready); else n_pass++;
    n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); else n_pass++;
    n_checks++; if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== 73'd0) $display("FAIL reset_outputs: got %h/%h/%b expected 0", m_axis_tdata, m_axis_tkeep, m_axis_tlast); else n_pass++;
    n_checks++; if (event_count !== 32'd0) $display("FAIL reset_event_count: got %0d expected 0", event_count); else n_pass++;
    n_checks++; if (err_tlast !== 1'b0) $display("FAIL reset_err_tlast: got %b expected 0", err_tlast); else n_pass++;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_single();
    exp_q.delete(); got_q.delete(); timeouts = 0;
    run_event(12'h123, 20, -1);
    n_checks++; if (timeouts !== 0) $display("FAIL single_timeout: got %0d expected 0", timeouts); else n_pass++;
    n_checks++; if (got_q.size() !== 4) $display("FAIL single_beats: got %0d expected 4", got_q.size()); else n_pass++;
    if (got_q.size() > 0) begin
      n_checks++; if (got_q[0].data !== 64'h5446_1230_0000_1014) $display("FAIL single_header: got %h expected 5446123000001014", got_q[0].data); else n_pass++;
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL single_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (event_count !== ev_exp) $display("FAIL single_event_count: got %0d expected %0d", event_count, ev_exp); else n_pass++;
  endtask

  task automatic test_multi_frag();
    exp_q.delete(); got_q.delete(); timeouts = 0;
    run_event(12'hABC, 2048, -1);
    n_checks++; if (timeouts !== 0) $display("FAIL multi_timeout: got %0d expected 0", timeouts); else n_pass++;
    n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL multi_beats: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
    if (got_q.size() > 129) begin
      n_checks++; if (got_q[129].data[35:0] !== 36'h001_002_400) $display("FAIL multi_hdr2_fields: got %h expected 001002400", got_q[129].data[35:0]); else n_pass++;
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL multi_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (event_count !== ev_exp) $display("FAIL multi_event_count: got %0d expected %0d", event_count, ev_exp); else n_pass++;
  endtask

  task automatic test_remainder();
    exp_q.delete(); got_q.delete(); timeouts = 0;
    run_event(12'h00F, 1030, -1);
    n_checks++; if (timeouts !== 0) $display("FAIL rem_timeout: got %0d expected 0", timeouts); else n_pass++;
    n_checks++; if (got_q.size() !== 131) $display("FAIL rem_beats: got %0d expected 131", got_q.size()); else n_pass++;
    if (got_q.size() == 131) begin
      n_checks++; if (got_q[129].data[11:0] !== 12'd6) $display("FAIL rem_fbytes: got %0d expected 6", got_q[129].data[11:0]); else n_pass++;
      n_checks++; if (got_q[130].keep !== 8'h3F) $display("FAIL rem_tkeep: got %h expected 3f", got_q[130].keep); else n_pass++;
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL rem_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (event_count !== ev_exp) $display("FAIL rem_event_count: got %0d expected %0d", event_count, ev_exp); else n_pass++;
  endtask

  task automatic test_zero_len();
    exp_q.delete(); got_q.delete(); timeouts = 0;
    sdata_xfers = 0;
    s_data_tdata  = 64'hDEAD_BEEF_0000_0001;
    s_data_tvalid = 1'b1;
    run_event(12'h777, 0, -1);
    s_data_tvalid = 1'b0;
    n_checks++; if (timeouts !== 0) $display("FAIL zero_timeout: got %0d expected 0", timeouts); else n_pass++;
    n_checks++; if (got_q.size() !== 1) $display("FAIL zero_beats: got %0d expected 1", got_q.size()); else n_pass++;
    if (got_q.size() > 0) begin
      n_checks++; if (got_q[0] !== exp_q[0]) $display("FAIL zero_header: got %h expected %h", got_q[0], exp_q[0]); else n_pass++;
    end
    n_checks++; if (sdata_xfers !== 0) $display("FAIL zero_data_consumed: got %0d expected 0", sdata_xfers); else n_pass++;
    n_checks++; if (event_count !== ev_exp) $display("FAIL zero_event_count: got %0d expected %0d", event_count, ev_exp); else n_pass++;
  endtask

  task automatic test_random();
    int unsigned len;
    int nbad = 0;
    exp_q.delete(); got_q.delete(); timeouts = 0; stall_viol = 0;
    rand_ready = 1'b1;
    rand_valid = 1'b1;
    for (int e = 0; e < 20; e++) begin
      case (e)
        0: len = 1024;
        1: len = 1;
        2: len = 0;
        3: len = 1025;
        default: len = $urandom_range(0, 2600);
      endcase
      run_event(12'($urandom), len, -1);
    end
    rand_ready = 1'b0;
    rand_valid = 1'b0;
    n_checks++; if (timeouts !== 0) $display("FAIL rand_timeout: got %0d expected 0", timeouts); else n_pass++;
    n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL rand_beats: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        nbad++;
        if (nbad <= 10) $display("FAIL rand_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end else n_pass++;
    end
    n_checks++; if (stall_viol !== 0) $display("FAIL rand_stall_stable: got %0d violations expected 0", stall_viol); else n_pass++;
    n_checks++; if (err_tlast !== 1'b0) $display("FAIL rand_err_tlast: got %b expected 0", err_tlast); else n_pass++;
    n_checks++; if (event_count !== ev_exp) $display("FAIL rand_event_count: got %0d expected %0d", event_count, ev_exp); else n_pass++;
  endtask

  task automatic test_tlast_err_and_reset();
    exp_q.delete(); got_q.delete(); timeouts = 0;
    run_event(12'h042, 32, 1);
    n_checks++; if (err_tlast !== 1'b1) $display("FAIL err_tlast_set: got %b expected 1", err_tlast); else n_pass++;
    n_checks++; if (got_q.size() !== 5) $display("FAIL err_beats: got %0d expected 5", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL err_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    // partial event, then reset while a payload beat is on offer
    pay_q.delete();
    for (int i = 0; i < 8; i++) pay_q.push_back({$urandom, $urandom});
    fork
      send_ctrl(12'h055, 64);
      send_data(3, -1);
    join
    s_data_tdata  = pay_q[3];
    s_data_tvalid = 1'b1;
    #2;
    aresetn = 1'b0;
    #1;
    n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_mid_tvalid: got %b expected 0", m_axis_tvalid); else n_pass++;
    n_checks++; if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast, s_data_tready} !== 74'd0) $display("FAIL rst_mid_outputs: got %h/%h/%b/%b expected 0", m_axis_tdata, m_axis_tkeep, m_axis_tlast, s_data_tready); else n_pass++;
    n_checks++; if (s_ctrl_tready !== 1'b1) $display("FAIL rst_mid_ctrl_tready: got %b expected 1", s_ctrl_tready); else n_pass++;
    n_checks++; if (err_tlast !== 1'b0) $display("FAIL rst_mid_err_tlast: got %b expected 0", err_tlast); else n_pass++;
    n_checks++; if (event_count !== 32'd0) $display("FAIL rst_mid_event_count: got %0d expected 0", event_count); else n_pass++;
    s_data_tvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    ev_exp = '0;
    exp_q.delete(); got_q.delete(); timeouts = 0;
    run_event(12'h066, 8, -1);
    n_checks++; if (got_q.size() !== 2) $display("FAIL post_rst_beats: got %0d expected 2", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL post_rst_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (event_count !== ev_exp) $display("FAIL post_rst_event_count: got %0d expected %0d", event_count, ev_exp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_frag();
    test_remainder();
    test_zero_len();
    test_random();
    test_tlast_err_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
